// File: rtl/arb_mux_pkg.sv
// Shared constants for the arb_mux registered N-to-1 multiplexer.
package arb_mux_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
endpackage

// File: rtl/arb_mux_rr_pick.sv
// Round-robin picker: rotate the request vector so the search starts after
// rr_ptr, priority-encode the lowest request, then map back to a channel index.
module arb_mux_rr_pick #(
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [SEL_W-1:0]  rr_ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  // Modular add that stays correct for non-power-of-two channel counts.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_CH) s = s - NUM_CH;
    return SEL_W'(s);
  endfunction

  logic [NUM_CH-1:0] rot;
  logic [SEL_W-1:0]  start_idx;
  logic [SEL_W-1:0]  pos;
  logic              pos_valid;

  always_comb begin
    start_idx = wrap_add(rr_ptr, 1);
    rot       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rot[i] = in_valid[wrap_add(start_idx, i)];
    end
    pos       = '0;
    pos_valid = 1'b0;
    // Descending scan leaves the lowest set position as the final winner.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos       = SEL_W'(i);
        pos_valid = 1'b1;
      end
    end
    grant       = wrap_add(start_idx, int'(pos));
    grant_valid = pos_valid;
  end

endmodule

// File: rtl/arb_mux.sv
// Registered N-to-1 mux with explicit-select or round-robin arbitration and a
// single output register that can drain and refill in the same cycle.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Handshake: a word moves on in_valid[k] & in_ready[k]; the output word
  // moves on out_valid & out_ready. in_ready is one-hot on the granted channel.

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] rr_grant, grant;
  logic             rr_grant_valid, sel_hit, grant_valid;
  logic             can_load, xfer;
  logic [WIDTH-1:0] grant_data;

  arb_mux_rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .in_valid    (in_valid),
    .rr_ptr      (rr_ptr_q),
    .grant       (rr_grant),
    .grant_valid (rr_grant_valid)
  );

  always_comb begin
    // Compare-based lookup so an out-of-range sel simply matches nothing.
    sel_hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) sel_hit = in_valid[k];
    end

    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end else begin
      grant       = sel;
      grant_valid = sel_hit;
    end

    can_load   = !out_valid_q || out_ready;
    xfer       = grant_valid && can_load;
    in_ready   = '0;
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant == SEL_W'(k)) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = xfer;
      end
    end

    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      rr_ptr_d    = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(NUM_CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a 4-channel instance for the main scenarios and
// a 3-channel instance for the out-of-range select case.
module tb_arb_mux;
  import arb_mux_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  // 4-channel instance
  logic          mode;
  logic [1:0]    sel;
  logic [4*W-1:0] in_data;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_ch;
  logic          out_valid;
  logic          out_ready;

  // 3-channel instance
  logic          mode3;
  logic [1:0]    sel3;
  logic [3*W-1:0] in_data3;
  logic [2:0]    in_valid3;
  logic [2:0]    in_ready3;
  logic [W-1:0]  out_data3;
  logic [1:0]    out_ch3;
  logic          out_valid3;
  logic          out_ready3;

  int n_checks = 0;
  int n_fail   = 0;

  arb_mux #(.WIDTH(W), .NUM_CH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(W), .NUM_CH(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_out_ch",    32'(out_ch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    mode       = MODE_SEL;
    sel        = 2'd0;
    in_data    = {32'd3, 32'd2, 32'd1, 32'd0};
    in_valid   = 4'b0000;
    out_ready  = 1'b1;
    mode3      = MODE_SEL;
    sel3       = 2'd0;
    in_data3   = {32'd2, 32'd1, 32'd0};
    in_valid3  = 3'b000;
    out_ready3 = 1'b1;

    // 1. Reset, then explicit select stepping 0..3
    do_reset();
    check("rst3_out_valid", 32'(out_valid3), 32'd0);
    in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check("sel_in_ready", 32'(in_ready), 32'(1 << s));
      tick();
      check("sel_out_data",  out_data, 32'(s));
      check("sel_out_ch",    32'(out_ch), 32'(s));
      check("sel_out_valid", 32'(out_valid), 32'd1);
    end

    // 2. Round-robin, all valid: last grant was 3 so the rotation starts at 0
    mode = MODE_RR;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
      tick();
      check("rr_out_ch",    32'(out_ch), 32'(i % 4));
      check("rr_out_valid", 32'(out_valid), 32'd1);
    end

    // 3. Round-robin with only channels 1 and 3 requesting, from reset pointer
    do_reset();
    mode     = MODE_RR;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr2_in_ready", 32'(in_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
      tick();
      check("rr2_out_ch",   32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
      check("rr2_out_data", out_data,    (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // 4. Load 5, stall three cycles, then drain and refill in one cycle
    mode     = MODE_SEL;
    in_data  = {32'd3, 32'd2, 32'd5, 32'd0};
    in_valid = 4'b1111;
    sel      = 2'd1;
    #1;
    check("ld5_in_ready", 32'(in_ready), 32'h2);
    tick();
    check("ld5_out_data", out_data, 32'd5);
    out_ready = 1'b0;
    #1;
    check("stall_in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_out_data",  out_data, 32'd5);
      check("stall_out_ch",    32'(out_ch), 32'd1);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready",  32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    #1;
    check("refill_in_ready", 32'(in_ready), 32'h4);
    tick();
    check("refill_out_data",  out_data, 32'd2);
    check("refill_out_ch",    32'(out_ch), 32'd2);
    check("refill_out_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_out_data",  out_data, 32'd2);
    check("drain_out_ch",    32'(out_ch), 32'd2);
    // Pointer followed the explicit-select grant of channel 2
    mode     = MODE_RR;
    in_valid = 4'b1111;
    #1;
    check("ptr_from_sel_in_ready", 32'(in_ready), 32'h8);
    tick();
    check("ptr_from_sel_out_ch", 32'(out_ch), 32'd3);

    // 5. Three channels, out-of-range select never grants
    in_valid3 = 3'b111;
    sel3      = 2'd2;
    #1;
    check("ch3_in_ready", 32'(in_ready3), 32'h4);
    tick();
    check("ch3_out_data", out_data3, 32'd2);
    sel3 = 2'd3;
    #1;
    check("oor_in_ready", 32'(in_ready3), 32'd0);
    tick();
    check("oor_out_valid", 32'(out_valid3), 32'd0);
    check("oor_out_data",  out_data3, 32'd2);

    // 6. Asynchronous reset mid-stream
    in_data  = {32'd3, 32'd2, 32'd1, 32'd0};
    tick();
    tick();
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    do_reset();
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("post_rst_out_ch",    32'(out_ch), 32'd0);
    check("post_rst_out_valid", 32'(out_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
